tetris_render_pipe: RTL

//  Parametrised, pipelined playfield renderer: per-pixel RGB for border, locked board cells (per-cell colour code), active piece and line-clear flash.

---
 rtl/tetris_render_if.sv | 35 +++
 rtl/tetris_render_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tetris_render_if.sv
// Pixel, piece, board-RAM and line-clear signals shared by the playfield renderer
// and the VGA/game-logic side that drives it.
interface tetris_render_if #(
  parameter int COLS = 10,
  parameter int ROWS = 20
);
  logic [9:0]          DrawX;
  logic [9:0]          DrawY;
  logic                frame_start;
  logic [39:0]         piece_x;
  logic [39:0]         piece_y;
  logic                piece_valid;
  logic [2:0]          shape;
  logic [4:0]          board_raddr;
  logic [3*COLS-1:0]   board_rdata;
  logic                clear_req;
  logic [ROWS-1:0]     clear_rows;
  logic                clear_busy;
  logic                clear_done;
  logic [3:0]          red;
  logic [3:0]          green;
  logic [3:0]          blue;

  modport master (
    output DrawX, DrawY, frame_start, piece_x, piece_y, piece_valid, shape,
    output board_rdata, clear_req, clear_rows,
    input  board_raddr, clear_busy, clear_done, red, green, blue
  );

  modport slave (
    input  DrawX, DrawY, frame_start, piece_x, piece_y, piece_valid, shape,
    input  board_rdata, clear_req, clear_rows,
    output board_raddr, clear_busy, clear_done, red, green, blue
  );
endinterface

// File: rtl/tetris_render_pipe.sv
// Two-stage playfield renderer: geometry and piece hit in stage 1 (aligned with the
// board row RAM read), colour priority in stage 2, plus the line-clear flash FSM.
module tetris_render_pipe #(
  parameter int CELL_LOG2       = 4,
  parameter int COLS            = 10,
  parameter int ROWS            = 20,
  parameter int ORIGIN_X        = 240,
  parameter int ORIGIN_Y        = 60,
  parameter int BORDER          = 2,
  parameter int FLASH_FRAMES    = 16,
  parameter int FLASH_HALF_LOG2 = 2
) (
  input  logic          pixel_clk,
  input  logic          Reset,
  tetris_render_if.slave bus
);

  localparam int COL_W = $clog2(COLS);
  localparam int CNT_W = $clog2(FLASH_FRAMES);

  localparam logic signed [10:0] FIELD_W = 11'(COLS << CELL_LOG2);
  localparam logic signed [10:0] FIELD_H = 11'(ROWS << CELL_LOG2);
  localparam logic signed [10:0] BRD     = 11'(BORDER);
  localparam logic signed [10:0] OX      = 11'(ORIGIN_X);
  localparam logic signed [10:0] OY      = 11'(ORIGIN_Y);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FLASH, DONE} flash_state_e;

  function automatic logic [11:0] palette(input logic [2:0] code);
    case (code)
      3'd1:    return 12'h0AA;
      3'd2:    return 12'hFF5;
      3'd3:    return 12'hA0A;
      3'd4:    return 12'h00F;
      3'd5:    return 12'h550;
      3'd6:    return 12'h5F5;
      3'd7:    return 12'hA00;
      default: return 12'h000;
    endcase
  endfunction

  // ---------------- stage 0: geometry from the current pixel ----------------
  logic signed [10:0] dx, dy, col_s, row_s;
  logic in_x, in_y, near_x, near_y, gap, hit;

  assign dx     = $signed({1'b0, bus.DrawX}) - OX;
  assign dy     = $signed({1'b0, bus.DrawY}) - OY;
  assign in_x   = (dx >= 11'sd0) && (dx < FIELD_W);
  assign in_y   = (dy >= 11'sd0) && (dy < FIELD_H);
  assign near_x = (dx >= -BRD) && (dx < FIELD_W + BRD);
  assign near_y = (dy >= -BRD) && (dy < FIELD_H + BRD);
  assign col_s  = dx >>> CELL_LOG2;
  assign row_s  = 11'(ROWS - 1) - (dy >>> CELL_LOG2);
  assign gap    = (dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0);

  assign bus.board_raddr = in_y ? row_s[4:0] : 5'd0;

  // Matching against an in-field col/row also rejects piece cells beyond COLS/ROWS.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (({1'b0, bus.piece_x[10*i +: 10]} == col_s) &&
          ({1'b0, bus.piece_y[10*i +: 10]} == row_s))
        hit = 1'b1;
    end
    hit = hit && bus.piece_valid && in_x && in_y;
  end

  // ---------------- stage 1 registers ----------------
  logic             border_q, outside_q, gap_q, hit_q;
  logic [2:0]       shape_q;
  logic [4:0]       row_q;
  logic [COL_W-1:0] col_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the stage registers are reset too so no stale pixel leaks out.
  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      border_q  <= 1'b0;
      outside_q <= 1'b1;
      gap_q     <= 1'b0;
      hit_q     <= 1'b0;
      shape_q   <= 3'd0;
      row_q     <= 5'd0;
      col_q     <= '0;
    end else begin
      border_q  <= near_x && near_y && !(in_x && in_y);
      outside_q <= !(in_x && in_y);
      gap_q     <= gap;
      hit_q     <= hit;
      shape_q   <= bus.shape;
      row_q     <= row_s[4:0];
      col_q     <= col_s[COL_W-1:0];
    end
  end

  // ---------------- flash FSM ----------------
  flash_state_e     state_q, state_d;
  logic [ROWS-1:0]  mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clear_req) state_d = (|bus.clear_rows) ? FLASH : DONE;
      FLASH:   if (bus.frame_start && (cnt_q == CNT_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (Reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == FLASH);
      done_q  <= (state_q == DONE);
      if ((state_q == IDLE) && bus.clear_req && (|bus.clear_rows)) begin
        mask_q <= bus.clear_rows;
        cnt_q  <= '0;
      end else if ((state_q == FLASH) && bus.frame_start) begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.clear_busy = busy_q;
  assign bus.clear_done = done_q;

  // ---------------- stage 2: colour priority ----------------
  logic [2:0]  code;
  logic        flash_row;
  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    code = 3'd0;
    for (int c = 0; c < COLS; c++) begin
      if (col_q == COL_W'(c)) code = bus.board_rdata[3*c +: 3];
    end
  end

  assign flash_row = (state_q == FLASH) && mask_q[row_q];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rgb_d = 12'h000;
    if (border_q)       rgb_d = 12'hFFF;
    else if (outside_q) rgb_d = 12'h555;
    else if (gap_q)     rgb_d = 12'h000;
    else if (hit_q)     rgb_d = palette(3'(shape_q + 3'd1));
    else if (flash_row) rgb_d = cnt_q[FLASH_HALF_LOG2] ? 12'h000 : 12'hFFF;
    else                rgb_d = palette(code);
  end

  always_ff @(posedge pixel_clk) begin
    if (Reset) rgb_q <= 12'h000;
    else       rgb_q <= rgb_d;
  end

  assign bus.red   = rgb_q[11:8];
  assign bus.green = rgb_q[7:4];
  assign bus.blue  = rgb_q[3:0];

endmodule
